branch_predictor_gshare: RTL and testbench
==========================================

Name: branch_predictor_gshare

Overview:
Parametrised successor to the single-mode IF-stage predictor. It combines a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of saturating counters. The PHT is indexed in one of three modes: static, bimodal or gshare. The block sits in IF and gives the PC mux a next-PC guess each cycle. It receives resolved outcomes from the stage that resolves control flow, and keeps lookup and mispredict statistics.

Parameters:
BTB_ENTRIES, 32, number of BTB and PHT entries; power of two ≥ 4; IDX = log2(BTB_ENTRIES)
GHR_BITS, 5, global history length; 1 ≤ GHR_BITS ≤ IDX
CTR_BITS, 2, PHT counter width; 2 to 4
MODE, 2, 0 = static not-taken, 1 = bimodal (PC-indexed), 2 = gshare (PC XOR history)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
current_pc  in  32  IF-stage PC being fetched
prediction  out  1  predicted taken
predicted_pc  out  32  predicted next PC
prediction_ghr  out  GHR_BITS  history snapshot used for this lookup; carried down the pipeline
update_valid  in  1  a control-flow instruction resolved this cycle
pc_to_update  in  32  PC of the resolved instruction
update_is_cond  in  1  1 = conditional branch, 0 = jal/jalr
actual_taken  in  1  resolved direction; always 1 for jal/jalr
branch_target  in  32  resolved target
update_ghr  in  GHR_BITS  prediction_ghr value carried with the resolved instruction
is_correct  in  1  earlier prediction matched the actual outcome
lookup_count  out  32  cycles with reset low
mispredict_count  out  32  resolved updates with is_correct low

Behaviour:
- Address split:
  - idx = pc[IDX+1:2]
  - tag = pc[31:IDX+2]
  - PC bits [1:0] are ignored.
- BTB entry = {valid, tag, target[31:0], cond}.
- PHT entry = CTR_BITS unsigned counter. "Taken" means MSB = 1.
- Lookup (combinational from current state, no bypass of same-cycle updates):
  - hit = valid[idx] && tag match.
  - PHT index: MODE 1 uses idx; MODE 2 uses idx XOR zero-extended GHR.
  - Take decision:
    - hit && !cond → taken in all modes.
    - hit && cond → taken iff MODE ≠ 0 and counter MSB = 1.
    - miss → not taken.
  - Taken: prediction = 1, predicted_pc = target.
  - Not taken: prediction = 0, predicted_pc = current_pc + 4, 32-bit wrap (0xFFFFFFFC → 0x0).
  - prediction_ghr = GHR, always.
- Update (posedge clk, when update_valid && !reset):
  - PHT (conditional only, MODE ≠ 0):
    - Index is recomputed from pc_to_update and update_ghr, not the live GHR.
    - Counter increments if taken, decrements if not, saturating at 2^CTR_BITS−1 and 0.
  - BTB (actual_taken only): write entry = {1, tag, branch_target, update_is_cond}. Not-taken updates never invalidate.
  - GHR (conditional only): GHR <= {update_ghr[GHR_BITS−2:0], actual_taken}. GHR_BITS = 1 uses {actual_taken}. Non-speculative, so an older branch resolving repairs history.
  - mispredict_count increments if !is_correct, saturating at 0xFFFFFFFF.
- lookup_count increments every cycle reset is low, saturating at 0xFFFFFFFF.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. The new value is visible the next cycle.
- Reset (synchronous, any time including mid-update):
  - All valid bits = 0.
  - All counters = 2^(CTR_BITS−1)−1 (weakly not-taken; 1 for CTR_BITS = 2).
  - GHR = 0; both statistics counters = 0.
  - An update presented in the reset cycle is discarded.
  - Outputs in and after the reset cycle: prediction = 0, predicted_pc = current_pc + 4, prediction_ghr = 0.
- Single-cycle latency: no handshake and no stall input. The pipeline holds current_pc during stalls; no update is lost because update_valid is sampled every cycle.

Test Plan:
- Reset then current_pc = 0x100 → prediction = 0, predicted_pc = 0x104, prediction_ghr = 0, counters 0. current_pc = 0xFFFFFFFC → predicted_pc = 0x0.
- Update jal: pc 0x100, target 0x200, cond = 0, taken. Next cycle, current_pc = 0x100 → prediction = 1, predicted_pc = 0x200 (MODE 0, 1 and 2).
- MODE = 1, conditional branch at 0x40 with target 0x80:
  - One taken update → counter 1→2, predicts 0x80.
  - Three not-taken updates → counter 0 (saturated), predicts 0x44.
  - Two taken updates → predicts 0x80.
- Aliasing: entry written for 0x100 (idx 0, tag 2). Lookup 0x180 (idx 0, tag 3) → miss, predicted_pc = 0x184.
- MODE = 2: three taken conditional updates each with update_ghr = current prediction_ghr → prediction_ghr = 5'b00111. Five not-taken updates → 0. A stale update_ghr = 5'b11000 with taken → GHR = 5'b10001.
- Update and lookup of 0x100 in the same cycle → old prediction that cycle, new one the next. Reset asserted with update_valid = 1 → no BTB write. mispredict_count counts only updates with is_correct = 0 (3 of 5 → 3).

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: IF-stage next-PC predictor built from a direct-mapped
// BTB and a PHT of saturating counters. The PHT index is unused (static),
// PC-derived (bimodal) or PC XOR global history (gshare) depending on MODE.
module branch_predictor_gshare #(
  parameter int BTB_ENTRIES = 32,
  parameter int GHR_BITS    = 5,
  parameter int CTR_BITS    = 2,
  parameter int MODE        = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  output logic                prediction,
  output logic [31:0]         predicted_pc,
  output logic [GHR_BITS-1:0] prediction_ghr,
  input  logic                update_valid,
  input  logic [31:0]         pc_to_update,
  input  logic                update_is_cond,
  input  logic                actual_taken,
  input  logic [31:0]         branch_target,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                is_correct,
  output logic [31:0]         lookup_count,
  output logic [31:0]         mispredict_count
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

  logic [BTB_ENTRIES-1:0]               btb_valid;
  logic [BTB_ENTRIES-1:0]               btb_cond;
  logic [TAG_W-1:0]                     btb_tag    [BTB_ENTRIES];
  logic [31:0]                          btb_target [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0][CTR_BITS-1:0] pht;
  logic [GHR_BITS-1:0]                  ghr;

  logic [IDX-1:0]      lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [IDX-1:0]      lk_pht_idx;
  logic                lk_hit;
  logic                lk_msb;
  logic                lk_taken;

  logic [IDX-1:0]      up_idx;
  logic [TAG_W-1:0]    up_tag;
  logic [IDX-1:0]      up_pht_idx;
  logic [GHR_BITS-1:0] ghr_next;

  logic                unused_pc_bits;

  // Gshare folds the history into the low index bits; other modes use the PC index alone.
  function automatic logic [IDX-1:0] pht_index(input logic [IDX-1:0]      idx,
                                               input logic [GHR_BITS-1:0] hist);
    return (MODE == 2) ? (idx ^ IDX'(hist)) : idx;
  endfunction

  assign lk_idx     = current_pc[IDX+1:2];
  assign lk_tag     = current_pc[31:IDX+2];
  assign lk_pht_idx = pht_index(lk_idx, ghr);

  // The resolved instruction's history snapshot, not the live GHR, picks its counter.
  assign up_idx     = pc_to_update[IDX+1:2];
  assign up_tag     = pc_to_update[31:IDX+2];
  assign up_pht_idx = pht_index(up_idx, update_ghr);
  assign ghr_next   = GHR_BITS'({update_ghr, actual_taken});

  assign unused_pc_bits = ^{current_pc[1:0], pc_to_update[1:0]};

  // Lookup reads only registered state, so a same-cycle update shows up one cycle later.
  always_comb begin
    lk_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    lk_msb   = pht[lk_pht_idx][CTR_BITS-1];
    lk_taken = 1'b0;
    if (!reset && lk_hit) begin
      if (!btb_cond[lk_idx]) begin
        lk_taken = 1'b1;
      end else begin
        lk_taken = (MODE != 0) && lk_msb;
      end
    end
    prediction     = lk_taken;
    predicted_pc   = lk_taken ? btb_target[lk_idx] : current_pc + 32'd4;
    prediction_ghr = reset ? '0 : ghr;
  end

  // Valid bits, counters, history and statistics; an update in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid        <= '0;
      pht              <= {BTB_ENTRIES{CTR_INIT}};
      ghr              <= '0;
      lookup_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (lookup_count != '1) begin
        lookup_count <= lookup_count + 32'd1;
      end
      if (update_valid) begin
        if ((MODE != 0) && update_is_cond) begin
          if (actual_taken && (pht[up_pht_idx] != '1)) begin
            pht[up_pht_idx] <= pht[up_pht_idx] + CTR_ONE;
          end else if (!actual_taken && (pht[up_pht_idx] != '0)) begin
            pht[up_pht_idx] <= pht[up_pht_idx] - CTR_ONE;
          end
        end
        if (actual_taken) begin
          btb_valid[up_idx] <= 1'b1;
        end
        if (update_is_cond) begin
          ghr <= ghr_next;
        end
        if (!is_correct && (mispredict_count != '1)) begin
          mispredict_count <= mispredict_count + 32'd1;
        end
      end
    end
  end

  // BTB payload needs no reset because the valid bits gate every read of it.
  always_ff @(posedge clk) begin
    if (!reset && update_valid && actual_taken) begin
      btb_tag[up_idx]    <= up_tag;
      btb_target[up_idx] <= branch_target;
      btb_cond[up_idx]   <= update_is_cond;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: drives one predictor per MODE (0, 1, 2) from shared
// inputs and compares every output against a table-based reference model.
module tb_branch_predictor_gshare;

  localparam int ENTRIES = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        update_valid;
  logic [31:0] pc_to_update;
  logic        update_is_cond;
  logic        actual_taken;
  logic [31:0] branch_target;
  logic [4:0]  update_ghr;
  logic        is_correct;

  logic        pred [3];
  logic [31:0] ppc  [3];
  logic [4:0]  pghr [3];
  logic [31:0] lcnt [3];
  logic [31:0] mcnt [3];

  int assertions = 0;
  int failures   = 0;

  // Reference model state: BTB as plain tables, counters as integers 0..3.
  bit          mValid  [ENTRIES];
  logic [31:0] mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  bit          mCond   [ENTRIES];
  int          mCtr    [3][ENTRIES];
  int          mGhr;
  logic [31:0] mLookups;
  logic [31:0] mMisp;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    branch_predictor_gshare #(
      .BTB_ENTRIES(32), .GHR_BITS(5), .CTR_BITS(2), .MODE(m)
    ) dut (
      .clk(clk), .reset(reset), .current_pc(current_pc),
      .prediction(pred[m]), .predicted_pc(ppc[m]), .prediction_ghr(pghr[m]),
      .update_valid(update_valid), .pc_to_update(pc_to_update),
      .update_is_cond(update_is_cond), .actual_taken(actual_taken),
      .branch_target(branch_target), .update_ghr(update_ghr), .is_correct(is_correct),
      .lookup_count(lcnt[m]), .mispredict_count(mcnt[m])
    );
  end

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd32);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] pc);
    return pc / 32'd128;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 0;
      for (int m = 0; m < 3; m++) mCtr[m][i] = 1;
    end
    mGhr     = 0;
    mLookups = 0;
    mMisp    = 0;
  endfunction

  function automatic void modelPredict(input int mode, input logic [31:0] pc,
                                       output bit taken, output logic [31:0] npc);
    int i;
    i = idxOf(pc);
    taken = 0;
    if (mValid[i] && (mTag[i] == tagOf(pc))) begin
      if (!mCond[i])      taken = 1;
      else if (mode == 1) taken = (mCtr[1][i] >= 2);
      else if (mode == 2) taken = (mCtr[2][i ^ mGhr] >= 2);
    end
    npc = taken ? mTarget[i] : pc + 32'd4;
  endfunction

  function automatic void modelCommit();
    int i;
    int p;
    if (mLookups != 32'hFFFF_FFFF) mLookups = mLookups + 1;
    if (update_valid) begin
      i = idxOf(pc_to_update);
      if (update_is_cond) begin
        for (int m = 1; m < 3; m++) begin
          p = (m == 1) ? i : (i ^ int'(update_ghr));
          if (actual_taken && mCtr[m][p] < 3)       mCtr[m][p]++;
          else if (!actual_taken && mCtr[m][p] > 0) mCtr[m][p]--;
        end
        mGhr = (int'(update_ghr) * 2 + int'(actual_taken)) % 32;
      end
      if (actual_taken) begin
        mValid[i]  = 1;
        mTag[i]    = tagOf(pc_to_update);
        mTarget[i] = branch_target;
        mCond[i]   = update_is_cond;
      end
      if (!is_correct && mMisp != 32'hFFFF_FFFF) mMisp = mMisp + 1;
    end
  endfunction

  task automatic checkValue(input string name, input logic [31:0] observed,
                            input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                               input logic cond, input logic taken, input logic [31:0] tgt,
                               input logic [4:0] ughr, input logic corr);
    current_pc     = pc;
    update_valid   = uv;
    pc_to_update   = upc;
    update_is_cond = cond;
    actual_taken   = taken;
    branch_target  = tgt;
    update_ghr     = ughr;
    is_correct     = corr;
  endtask

  task automatic checkOutput();
    bit          expTaken;
    logic [31:0] expPc;
    for (int m = 0; m < 3; m++) begin
      modelPredict(m, current_pc, expTaken, expPc);
      if (reset) begin
        expTaken = 0;
        expPc    = current_pc + 32'd4;
      end
      checkValue($sformatf("prediction_m%0d", m), 32'(pred[m]), 32'(expTaken));
      checkValue($sformatf("predicted_pc_m%0d", m), ppc[m], expPc);
      checkValue($sformatf("prediction_ghr_m%0d", m), 32'(pghr[m]), reset ? 32'd0 : 32'(mGhr));
      checkValue($sformatf("lookup_count_m%0d", m), lcnt[m], mLookups);
      checkValue($sformatf("mispredict_count_m%0d", m), mcnt[m], mMisp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    if (reset) modelReset();
    else       modelCommit();
    #1;
  endtask

  task automatic doCycle(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic cond, input logic taken, input logic [31:0] tgt,
                         input logic [4:0] ughr, input logic corr);
    applyStimulus(pc, uv, upc, cond, taken, tgt, ughr, corr);
    #1;
    checkOutput();
    stepClock();
  endtask

  task automatic peek(input logic [31:0] pc);
    applyStimulus(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    #1;
    checkOutput();
  endtask

  function automatic logic [31:0] randPc();
    if ($urandom_range(0, 9) == 0) return $urandom();
    return 32'($urandom_range(2, 3)) * 32'd128 + 32'($urandom_range(0, 7)) * 32'd4
           + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic        rCond;
    logic [4:0]  rGhr;

    $display("[TB] starting gshare predictor bench");
    reset = 1'b1;
    applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    stepClock();

    // An update offered while reset is high must not reach the BTB.
    doCycle(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 5'h0, 1'b1);
    reset = 1'b0;

    peek(32'h100);
    checkValue("reset_prediction", 32'(pred[2]), 32'd0);
    checkValue("reset_predicted_pc", ppc[1], 32'h104);
    checkValue("reset_ghr", 32'(pghr[2]), 32'd0);
    checkValue("reset_lookup_count", lcnt[0], 32'd0);
    checkValue("reset_mispredict_count", mcnt[0], 32'd0);
    stepClock();

    peek(32'hFFFF_FFFC);
    checkValue("wrap_pc", ppc[0], 32'h0);
    checkValue("lookup_count_one", lcnt[2], 32'd1);
    stepClock();

    // jal update and lookup of the same PC in one cycle: old answer now, new one next.
    applyStimulus(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 5'(mGhr), 1'b0);
    #1;
    checkOutput();
    checkValue("same_cycle_old", ppc[1], 32'h104);
    stepClock();

    peek(32'h100);
    for (int m = 0; m < 3; m++) begin
      checkValue($sformatf("jal_pred_m%0d", m), 32'(pred[m]), 32'd1);
      checkValue($sformatf("jal_target_m%0d", m), ppc[m], 32'h200);
    end
    stepClock();

    peek(32'h180);
    checkValue("alias_miss", ppc[2], 32'h184);
    stepClock();

    // Bimodal counter walk for the conditional branch at 0x40.
    doCycle(32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 5'(mGhr), 1'b1);
    peek(32'h40);
    checkValue("bimodal_taken_once", ppc[1], 32'h80);
    checkValue("static_cond_not_taken", ppc[0], 32'h44);
    stepClock();
    for (int k = 0; k < 3; k++) doCycle(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 5'(mGhr), 1'b1);
    peek(32'h40);
    checkValue("bimodal_saturated_low", ppc[1], 32'h44);
    stepClock();
    for (int k = 0; k < 2; k++) doCycle(32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 5'(mGhr), 1'b1);
    peek(32'h40);
    checkValue("bimodal_retrained", ppc[1], 32'h80);
    stepClock();

    // Mispredict statistic counts only updates flagged incorrect.
    reset = 1'b1;
    doCycle(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++)
      doCycle(32'h0, 1'b1, 32'h200 + 32'(k * 4), 1'b0, 1'b1, 32'h400, 5'(mGhr), 1'(k % 2));
    peek(32'h0);
    checkValue("mispredict_three_of_five", mcnt[0], 32'd3);
    stepClock();

    // Global history shifting, including repair from a stale snapshot.
    reset = 1'b1;
    doCycle(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h0, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) doCycle(32'h300, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 5'(mGhr), 1'b1);
    peek(32'h300);
    checkValue("ghr_three_taken", 32'(pghr[2]), 32'h07);
    stepClock();
    for (int k = 0; k < 5; k++) doCycle(32'h300, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 5'(mGhr), 1'b1);
    peek(32'h300);
    checkValue("ghr_five_not_taken", 32'(pghr[2]), 32'h00);
    stepClock();
    doCycle(32'h300, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 5'b11000, 1'b1);
    peek(32'h300);
    checkValue("ghr_stale_repair", 32'(pghr[2]), 32'h11);
    stepClock();

    // Randomized traffic against the model, with occasional reset.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      rCond = 1'($urandom_range(0, 1));
      rGhr  = ($urandom_range(0, 1) == 1) ? 5'(mGhr) : 5'($urandom_range(0, 31));
      doCycle(randPc(), ($urandom_range(0, 9) < 6), randPc(), rCond,
              rCond ? 1'($urandom_range(0, 1)) : 1'b1, $urandom(), rGhr,
              1'($urandom_range(0, 1)));
    end
    reset = 1'b0;
    peek(32'h100);
    stepClock();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
